video_stream_checker: RTL and testbench
=======================================

Name: video_stream_checker

Overview:
- AXI4-Stream video sink: the receiving end of the video controller's pattern/video output stream.
- Accepts pixels and tracks SOF (TUSER) and EOL (TLAST), then measures frame geometry against the configured width/height.
- Counts complete frames and protocol/geometry errors.
- Used as an in-fabric monitor and loopback sink for bring-up of the video path and camera pipeline.

Parameters:
- DW, 24, TDATA width in bits (data is not inspected except under the optional feature).
- CW, 16, width of pixel/line counters and of the cfg_width/cfg_height ports.

Ports:
- clk  in  1  stream clock
- rst  in  1  synchronous, active-high reset
- en  in  1  enable; low forces tready=0 and resyncs the FSM
- cfg_width  in  CW  expected pixels per line; 0 = measure only
- cfg_height  in  CW  expected lines per frame; 0 = measure only
- clr_err  in  1  single-cycle pulse; clears err_flags and err_cnt
- s_tdata  in  DW  pixel data
- s_tvalid  in  1  source valid
- s_tuser  in  1  start of frame (first pixel of line 0)
- s_tlast  in  1  end of line (last pixel of each line)
- s_tready  out  1  sink ready
- frame_done  out  1  one-cycle pulse per completed frame
- frame_cnt  out  32  completed frames, wraps modulo 2^32
- meas_width  out  CW  pixel count of the last line completed
- meas_height  out  CW  line count of the last frame terminated by height match or by early SOF
- err_flags  out  4  sticky: [0] NO_SOF, [1] LINE_LEN, [2] FRAME_SHORT, [3] DATA (optional feature)
- err_cnt  out  16  error events, saturating at 16'hFFFF

Behaviour:
- Reset: s_tready=0, FSM=SYNC, frame_done=0, all counters, meas_* and err_* = 0.
- Beat: s_tvalid & s_tready. s_tready is registered as en & ~rst.
  - Stays high whenever enabled; never depends on s_tvalid.
  - A beat is never lost or duplicated.
- cfg_width/cfg_height are latched on each SOF beat. Mid-frame cfg changes take effect at the next frame.
- SYNC state:
  - A beat with tuser=0 is discarded, sets NO_SOF and bumps err_cnt. One event per contiguous discarded run, not per beat.
  - A beat with tuser=1 becomes pixel 0 of line 0; go to ACTIVE.
- ACTIVE state, per beat:
  - tuser=1 (early SOF): set FRAME_SHORT, bump err_cnt, load meas_height=line. The beat starts a new frame at pixel 0, line 0; no frame_done.
  - tlast=1, end of line:
    - Load meas_width=px+1.
    - If cfg_width≠0 and px+1≠cfg_width, set LINE_LEN and bump err_cnt.
    - Then px=0 and line++.
    - If cfg_height≠0 and line+1==cfg_height, the frame is complete: load meas_height; next cycle frame_done=1 and frame_cnt++; go to SYNC.
  - No tlast and px+1==cfg_width (missing EOL): set LINE_LEN once for that line and keep counting until tlast.
  - cfg_height=0: frames end only at the next SOF. That SOF counts as frame_done, not FRAME_SHORT.
- Counters: px and line saturate at 2^CW-1, no wrap.
- Simultaneous events:
  - clr_err in the same cycle as a new error: the new error wins (flag set, err_cnt=1).
  - tuser & tlast on one beat: treated as SOF, then EOL of a 1-pixel line 0.
- en low: s_tready drops the next cycle; px/line clear; FSM=SYNC. frame_cnt and err_* are retained.
- Reset mid-frame: identical to power-up reset.
- Latency: frame_done and the frame_cnt update occur 1 cycle after the last beat. meas_* and err_* update 1 cycle after the causing beat.

Optional Feature:
- VIDEO_STREAM_CHECKER_DATA_EN
- Defined: each pixel is checked against the test-pattern value {line[7:0], px[7:0]} zero-extended to DW. A mismatch sets err_flags[3] and bumps err_cnt, at most one event per line.
- Undefined: no comparator logic; err_flags[3] is tied to 0.

Decomposition:
- Package video_stream_pkg:
  - state typedef (SYNC, ACTIVE)
  - error-bit index constants (ERR_NO_SOF=0, ERR_LINE_LEN=1, ERR_FRAME_SHORT=2, ERR_DATA=3)
  - ERR_CNT_MAX
- Sub-module video_geom_counter: px/line counters with saturation and EOL/EOF decode, reusable by the source-side generator.

Test Plan:
- cfg 16x10, three clean frames of 160 beats each, continuous valid:
  - frame_done pulses 3 times, each 1 cycle after the beat with tlast on line 9.
  - frame_cnt=3, meas_width=16, meas_height=10, err_flags=0.
- Line 4 has tlast on pixel 11:
  - LINE_LEN set, err_cnt=1, meas_width=12.
  - The frame still completes after 10 lines.
- 20 beats without tuser before the first SOF:
  - NO_SOF set, err_cnt=1 (not 20).
  - The following 16x10 frame is counted normally.
- SOF arrives during line 6:
  - FRAME_SHORT set, meas_height=6, no frame_done.
  - The next full frame gives frame_cnt=1.
- en low for 12 cycles mid-frame, then a full frame:
  - s_tready=0 throughout the gap.
  - No beats are accepted; px/line clear.
  - err_flags/err_cnt and frame_cnt are not changed by the gap.
  - The next full frame is counted as complete.
- cfg 0x0, 32x16 stream (the controller's second configuration):
  - meas_width=32, meas_height=16 on each next SOF; no errors.
- rst asserted mid-frame:
  - All outputs return to 0 the cycle after rst is sampled, per the reset values above.

Source files
------------

// File: rtl/video_stream_pkg.sv
// video_stream_pkg: shared types and constants for the video stream checker.
//   state_e          - checker FSM states (SYNC, ACTIVE)
//   ERR_*            - bit positions inside err_flags
//   ERR_CNT_MAX      - saturation value of the error event counter
//   err_cnt_add()    - saturating add of a small event count onto err_cnt
package video_stream_pkg;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int ERR_NO_SOF      = 0;
  localparam int ERR_LINE_LEN    = 1;
  localparam int ERR_FRAME_SHORT = 2;
  localparam int ERR_DATA        = 3;
  localparam int ERR_W           = 4;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] err_cnt_add(input logic [15:0] cnt, input logic [2:0] n);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {14'd0, n};
    return sum[16] ? ERR_CNT_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/video_geom_counter.sv
// video_geom_counter: pixel/line position counters for an AXI4-Stream video
// stream, saturating at 2^CW-1. Shared between sink checkers and generators.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   clr_i         - resync: clear both counters
//   beat_i        - an accepted pixel is presented this cycle
//   sof_i         - the pixel is the first of a frame (position forced to 0,0)
//   eol_i         - the pixel is the last of its line
//   eof_i         - the pixel ends the frame; counters return to 0,0
//   line_o        - registered line count (lines finished so far)
//   cur_px_o      - pixel index of the current beat (0 on SOF)
//   cur_line_o    - line index of the current beat (0 on SOF)
//   px_inc_o      - cur_px_o + 1, saturating
//   line_inc_o    - cur_line_o + 1, saturating
module video_geom_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          beat_i,
  input  logic          sof_i,
  input  logic          eol_i,
  input  logic          eof_i,
  output logic [CW-1:0] line_o,
  output logic [CW-1:0] cur_px_o,
  output logic [CW-1:0] cur_line_o,
  output logic [CW-1:0] px_inc_o,
  output logic [CW-1:0] line_inc_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] px_q, px_d;
  logic [CW-1:0] line_q, line_d;

  // An SOF beat is pixel 0 of line 0 regardless of where the counters were.
  assign cur_px_o   = sof_i ? '0 : px_q;
  assign cur_line_o = sof_i ? '0 : line_q;
  assign px_inc_o   = (cur_px_o == CNT_MAX) ? CNT_MAX : cur_px_o + CW'(1);
  assign line_inc_o = (cur_line_o == CNT_MAX) ? CNT_MAX : cur_line_o + CW'(1);
  assign line_o     = line_q;

  always_comb begin
    px_d   = px_q;
    line_d = line_q;
    if (clr_i) begin
      px_d   = '0;
      line_d = '0;
    end else if (beat_i) begin
      if (eof_i) begin
        px_d   = '0;
        line_d = '0;
      end else if (eol_i) begin
        px_d   = '0;
        line_d = line_inc_o;
      end else begin
        px_d   = px_inc_o;
        line_d = cur_line_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_q   <= '0;
      line_q <= '0;
    end else begin
      px_q   <= px_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/video_stream_checker.sv
// video_stream_checker: AXI4-Stream video sink that tracks SOF (tuser) and
// EOL (tlast), measures frame geometry against cfg_width/cfg_height, counts
// complete frames and sticky protocol/geometry errors.
// Optional feature: define VIDEO_STREAM_CHECKER_DATA_EN to compare every pixel
// against the test pattern {line[7:0], px[7:0]}; otherwise err_flags[3] is 0.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   en                       - enable; low drops s_tready and resyncs
//   cfg_width, cfg_height    - expected geometry (0 = measure only), latched at SOF
//   clr_err                  - clears err_flags/err_cnt
//   s_tdata/tvalid/tuser/tlast, s_tready - AXI4-Stream sink
//   frame_done, frame_cnt    - frame completion pulse and wrapping count
//   meas_width, meas_height  - measured geometry
//   err_flags, err_cnt       - sticky error bits and saturating event count
module video_stream_checker
  import video_stream_pkg::*;
#(
  parameter int DW = 24,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_height,
  input  logic          clr_err,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tuser,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic          frame_done,
  output logic [31:0]   frame_cnt,
  output logic [CW-1:0] meas_width,
  output logic [CW-1:0] meas_height,
  output logic [3:0]    err_flags,
  output logic [15:0]   err_cnt
);

  state_e        state_q, state_d;
  logic          tready_q;
  logic          frame_done_q, frame_done_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] meas_w_q, meas_w_d, meas_h_q, meas_h_d;
  logic [CW-1:0] cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
  logic [ERR_W-1:0] err_flags_q, err_flags_d, err_set;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [2:0]    n_err;
  logic          nosof_run_q, nosof_run_d;  // inside a run of discarded beats
  logic          len_err_q, len_err_d;      // LINE_LEN already raised this line

  logic          beat, acc, frame_end, len_flag;
  logic [CW-1:0] eff_w, eff_h;
  logic [CW-1:0] line_raw, cur_px, cur_line, px_inc, line_inc;

  assign beat  = s_tvalid & tready_q;
  // Only beats that belong to a frame advance the geometry counters.
  assign acc   = beat & en & ((state_q == ACTIVE) | s_tuser);
  // The SOF beat itself is already measured against the newly latched cfg.
  assign eff_w = s_tuser ? cfg_width  : cfg_w_q;
  assign eff_h = s_tuser ? cfg_height : cfg_h_q;
  assign len_flag = s_tuser ? 1'b0 : len_err_q;

  video_geom_counter #(.CW(CW)) u_geom (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (~en),
    .beat_i     (acc),
    .sof_i      (s_tuser),
    .eol_i      (s_tlast),
    .eof_i      (frame_end),
    .line_o     (line_raw),
    .cur_px_o   (cur_px),
    .cur_line_o (cur_line),
    .px_inc_o   (px_inc),
    .line_inc_o (line_inc)
  );

`ifdef VIDEO_STREAM_CHECKER_DATA_EN
  logic          data_err_q, data_err_d;    // DATA already raised this line
  logic [DW-1:0] exp_pix;
  assign exp_pix = {{(DW-16){1'b0}}, cur_line[7:0], cur_px[7:0]};
`else
  logic unused_data;
  assign unused_data = ^{s_tdata, cur_px, cur_line};
`endif

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    meas_w_d     = meas_w_q;
    meas_h_d     = meas_h_q;
    cfg_w_d      = cfg_w_q;
    cfg_h_d      = cfg_h_q;
    err_set      = '0;
    nosof_run_d  = nosof_run_q;
    len_err_d    = len_err_q;
    frame_end    = 1'b0;
`ifdef VIDEO_STREAM_CHECKER_DATA_EN
    data_err_d   = data_err_q;
`endif
    if (!en) begin
      state_d     = SYNC;
      nosof_run_d = 1'b0;
      len_err_d   = 1'b0;
`ifdef VIDEO_STREAM_CHECKER_DATA_EN
      data_err_d  = 1'b0;
`endif
    end else if (beat) begin
      if ((state_q == SYNC) && !s_tuser) begin
        if (!nosof_run_q) err_set[ERR_NO_SOF] = 1'b1;
        nosof_run_d = 1'b1;
      end else begin
        nosof_run_d = 1'b0;
        if (s_tuser) begin
          state_d   = ACTIVE;
          cfg_w_d   = cfg_width;
          cfg_h_d   = cfg_height;
          len_err_d = 1'b0;
          if (state_q == ACTIVE) begin
            // Measure-only height: the next SOF closes the frame normally.
            meas_h_d = line_raw;
            if (cfg_h_q == '0) frame_done_d = 1'b1;
            else               err_set[ERR_FRAME_SHORT] = 1'b1;
          end
        end
`ifdef VIDEO_STREAM_CHECKER_DATA_EN
        if (s_tdata != exp_pix && !(s_tuser ? 1'b0 : data_err_q)) begin
          err_set[ERR_DATA] = 1'b1;
          data_err_d        = 1'b1;
        end else if (s_tuser) begin
          data_err_d        = 1'b0;
        end
        if (s_tlast) data_err_d = 1'b0;
`endif
        if (s_tlast) begin
          meas_w_d  = px_inc;
          len_err_d = 1'b0;
          if (eff_w != '0 && px_inc != eff_w && !len_flag) err_set[ERR_LINE_LEN] = 1'b1;
          if (eff_h != '0 && line_inc == eff_h) begin
            frame_end    = 1'b1;
            meas_h_d     = line_inc;
            frame_done_d = 1'b1;
            state_d      = SYNC;
          end
        end else if (eff_w != '0 && px_inc == eff_w && !len_flag) begin
          // Missing EOL: flag once, keep counting until tlast shows up.
          err_set[ERR_LINE_LEN] = 1'b1;
          len_err_d             = 1'b1;
        end
      end
    end

    frame_cnt_d = frame_cnt_q + {31'd0, frame_done_d};

    n_err = '0;
    for (int i = 0; i < ERR_W; i++) n_err = n_err + {2'b00, err_set[i]};

    // A clear coinciding with a new error keeps only the new error.
    if (clr_err) begin
      err_flags_d = err_set;
      err_cnt_d   = err_cnt_add(16'd0, n_err);
    end else begin
      err_flags_d = err_flags_q | err_set;
      err_cnt_d   = err_cnt_add(err_cnt_q, n_err);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      tready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      meas_w_q     <= '0;
      meas_h_q     <= '0;
      cfg_w_q      <= '0;
      cfg_h_q      <= '0;
      err_flags_q  <= '0;
      err_cnt_q    <= '0;
      nosof_run_q  <= 1'b0;
      len_err_q    <= 1'b0;
`ifdef VIDEO_STREAM_CHECKER_DATA_EN
      data_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tready_q     <= en;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      meas_w_q     <= meas_w_d;
      meas_h_q     <= meas_h_d;
      cfg_w_q      <= cfg_w_d;
      cfg_h_q      <= cfg_h_d;
      err_flags_q  <= err_flags_d;
      err_cnt_q    <= err_cnt_d;
      nosof_run_q  <= nosof_run_d;
      len_err_q    <= len_err_d;
`ifdef VIDEO_STREAM_CHECKER_DATA_EN
      data_err_q   <= data_err_d;
`endif
    end
  end

  assign s_tready    = tready_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign meas_width  = meas_w_q;
  assign meas_height = meas_h_q;
  assign err_flags   = err_flags_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_video_stream_checker.sv
// tb_video_stream_checker: directed stimulus for video_stream_checker with a
// scoreboard queue of expected frame completions, popped by a monitor on every
// frame_done pulse, plus direct checks of sticky status after key beats.
module tb_video_stream_checker;

  localparam int DW = 24;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, en, clr_err;
  logic [CW-1:0] cfg_width, cfg_height;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tuser, s_tlast, s_tready;
  logic          frame_done;
  logic [31:0]   frame_cnt;
  logic [CW-1:0] meas_width, meas_height;
  logic [3:0]    err_flags;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  video_stream_checker #(.DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .clr_err     (clr_err),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tuser     (s_tuser),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .meas_width  (meas_width),
    .meas_height (meas_height),
    .err_flags   (err_flags),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    logic [31:0] cnt;
    logic [15:0] mw;
    logic [15:0] mh;
    logic [3:0]  ef;
    logic [15:0] ec;
    longint      due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 0;
  logic [3:0]  exp_ef = 0;
  logic [15:0] exp_ec = 0;
  longint      last_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Offer one beat; it is accepted at the returned-from posedge.
  task automatic beat(input logic u, input logic l, input logic [DW-1:0] d);
    int g = 0;
    @(negedge clk);
    s_tvalid = 1'b1; s_tuser = u; s_tlast = l; s_tdata = d;
    while (s_tready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: s_tready=%b, expected 1", s_tready);
    end
    @(posedge clk);
    last_edge = $time;
    #1 s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_line(input int ln, input int len, input bit sof);
    logic [15:0] pat;
    for (int p = 0; p < len; p++) begin
      pat = {ln[7:0], p[7:0]};
      beat(sof && (p == 0), p == len - 1, DW'(pat));
    end
  endtask

  task automatic push_exp(input logic [15:0] mw, input logic [15:0] mh);
    exp_cnt = exp_cnt + 1;
    exp_q.push_back('{cnt: exp_cnt, mw: mw, mh: mh, ef: exp_ef, ec: exp_ec, due: last_edge + 5});
  endtask

  task automatic send_frame(input int w, input int h);
    for (int l = 0; l < h; l++) send_line(l, w, l == 0);
    push_exp(16'(w), 16'(h));
  endtask

  task automatic clear_errors();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("clr_err_flags", 32'(err_flags), 32'd0);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    exp_ef = 0; exp_ec = 0;
  endtask

  // Monitor: every frame_done pulse must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_frame_done: frame_cnt=%0d, no completion expected (t=%0t)", frame_cnt, $time);
      end else begin
        mon_e = exp_q.pop_front();
        $display("frame_done seen: cnt=%0d w=%0d h=%0d flags=%b errs=%0d t=%0t",
                 frame_cnt, meas_width, meas_height, err_flags, err_cnt, $time);
        check("fd_time", 32'($time), 32'(mon_e.due));
        check("fd_frame_cnt", frame_cnt, mon_e.cnt);
        check("fd_meas_width", 32'(meas_width), 32'(mon_e.mw));
        check("fd_meas_height", 32'(meas_height), 32'(mon_e.mh));
        check("fd_err_flags", 32'(err_flags), 32'(mon_e.ef));
        check("fd_err_cnt", 32'(err_cnt), 32'(mon_e.ec));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    cfg_width = 16; cfg_height = 10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_err_flags", 32'(err_flags), 32'd0);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    check("en_tready", 32'(s_tready), 32'd1);

    // Three clean 16x10 frames.
    repeat (3) send_frame(16, 10);
    @(negedge clk);
    $display("clean frames: frame_cnt=%0d w=%0d h=%0d", frame_cnt, meas_width, meas_height);
    check("clean_frame_cnt", frame_cnt, 32'd3);
    check("clean_meas_width", 32'(meas_width), 32'd16);
    check("clean_meas_height", 32'(meas_height), 32'd10);
    check("clean_err_flags", 32'(err_flags), 32'd0);

    // Line 4 ends early at pixel 11.
    exp_ef = 4'b0010; exp_ec = 1;
    for (int l = 0; l < 10; l++) begin
      send_line(l, (l == 4) ? 12 : 16, l == 0);
      if (l == 4) begin
        @(negedge clk);
        $display("short line: w=%0d flags=%b errs=%0d", meas_width, err_flags, err_cnt);
        check("short_meas_width", 32'(meas_width), 32'd12);
        check("short_err_flags", 32'(err_flags), 32'b0010);
        check("short_err_cnt", 32'(err_cnt), 32'd1);
      end
    end
    push_exp(16, 10);
    clear_errors();

    // 20 beats without SOF, then a normal frame.
    repeat (20) beat(1'b0, 1'b0, '0);
    @(negedge clk);
    $display("no sof run: flags=%b errs=%0d", err_flags, err_cnt);
    check("nosof_err_flags", 32'(err_flags), 32'b0001);
    check("nosof_err_cnt", 32'(err_cnt), 32'd1);
    exp_ef = 4'b0001; exp_ec = 1;
    send_frame(16, 10);
    clear_errors();

    // SOF arrives during line 6.
    for (int l = 0; l < 6; l++) send_line(l, 16, l == 0);
    for (int p = 0; p < 5; p++) beat(1'b0, 1'b0, DW'(16'h0600 + p));
    exp_ef = 4'b0100; exp_ec = 1;
    send_line(0, 16, 1'b1);
    @(negedge clk);
    $display("early sof: h=%0d flags=%b errs=%0d", meas_height, err_flags, err_cnt);
    check("early_meas_height", 32'(meas_height), 32'd6);
    check("early_err_flags", 32'(err_flags), 32'b0100);
    check("early_err_cnt", 32'(err_cnt), 32'd1);
    for (int l = 1; l < 10; l++) send_line(l, 16, 1'b0);
    push_exp(16, 10);
    clear_errors();

    // en low for 12 cycles mid-frame; junk offered during the gap.
    for (int l = 0; l < 3; l++) send_line(l, 16, l == 0);
    @(negedge clk); en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("gap_tready", 32'(s_tready), 32'd0);
      s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0;
    end
    en = 1'b1; s_tvalid = 1'b0;
    @(negedge clk);
    $display("after gap: frame_cnt=%0d flags=%b errs=%0d", frame_cnt, err_flags, err_cnt);
    check("gap_frame_cnt", frame_cnt, 32'd6);
    check("gap_err_flags", 32'(err_flags), 32'd0);
    check("gap_err_cnt", 32'(err_cnt), 32'd0);
    send_frame(16, 10);

    // Measure-only mode, 32x16 frames closed by the next SOF.
    @(negedge clk); cfg_width = 0; cfg_height = 0;
    for (int f = 0; f < 4; f++) begin
      beat(1'b1, 1'b0, '0);
      if (f > 0) push_exp(32, 16);
      if (f < 3) begin
        for (int p = 1; p < 32; p++) beat(1'b0, p == 31, DW'(p));
        for (int l = 1; l < 16; l++) send_line(l, 32, 1'b0);
      end
    end
    @(negedge clk);
    $display("measure only: frame_cnt=%0d w=%0d h=%0d", frame_cnt, meas_width, meas_height);
    check("meas_frame_cnt", frame_cnt, 32'd10);
    check("meas_width_32", 32'(meas_width), 32'd32);
    check("meas_height_16", 32'(meas_height), 32'd16);
    check("meas_err_flags", 32'(err_flags), 32'd0);

    // Reset mid-frame.
    repeat (5) beat(1'b0, 1'b0, '0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    $display("mid-frame reset: tready=%b cnt=%0d w=%0d h=%0d", s_tready, frame_cnt, meas_width, meas_height);
    check("mrst_tready", 32'(s_tready), 32'd0);
    check("mrst_frame_done", 32'(frame_done), 32'd0);
    check("mrst_frame_cnt", frame_cnt, 32'd0);
    check("mrst_meas_width", 32'(meas_width), 32'd0);
    check("mrst_meas_height", 32'(meas_height), 32'd0);
    check("mrst_err_flags", 32'(err_flags), 32'd0);
    check("mrst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    // clr_err on the same cycle as a new NO_SOF error.
    clr_err = 1'b1;
    beat(1'b0, 1'b0, '0);
    clr_err = 1'b0;
    @(negedge clk);
    $display("clear vs error: flags=%b errs=%0d", err_flags, err_cnt);
    check("clrwin_err_flags", 32'(err_flags), 32'b0001);
    check("clrwin_err_cnt", 32'(err_cnt), 32'd1);

    repeat (3) @(negedge clk);
    check("pending_frame_done", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
